// File: rtl/nic_pkg.sv
// Shared register map and status-word layout for the NIC FIFO block.
package nic_pkg;

   localparam logic [1:0] ADDR_IN_DATA  = 2'b00;
   localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
   localparam logic [1:0] ADDR_OUT_DATA = 2'b10;
   localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

   // Status bit offsets, counted upward from the packet LSB.
   localparam int ST_NE_FULL = 0;
   localparam int ST_OVF     = 1;
   localparam int ST_ALT     = 2;
   localparam int ST_CNT     = 3;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; pushes when full and pops when empty are ignored.
module sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // DEPTH is a power of two, so pointers wrap naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/nic_fifo.sv
// NIC between a CPU register port and a router PE port, with DEPTH-entry FIFOs each way,
// polarity-gated injection and sticky overflow flags reported in the status words.
module nic_fifo
   import nic_pkg::*;
#(
   parameter int PACKET_WIDTH = 64,
   parameter int DEPTH        = 4,
   parameter int VC_BIT       = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [1:0]              addr,
   input  logic [PACKET_WIDTH-1:0] d_in,
   output logic [PACKET_WIDTH-1:0] d_out,
   input  logic                    nicEn,
   input  logic                    nicEnWR,
   input  logic                    net_si,
   input  logic                    net_ri,
   input  logic [PACKET_WIDTH-1:0] net_di,
   output logic                    net_so,
   output logic                    net_ro,
   output logic [PACKET_WIDTH-1:0] net_do,
   input  logic                    net_polarity
);

   localparam int CW = $clog2(DEPTH) + 1;
   // Packet index i (MSB-first numbering) lives at bit PACKET_WIDTH-1-i.
   localparam int VC_IDX = PACKET_WIDTH - 1 - VC_BIT;

   logic [PACKET_WIDTH-1:0] in_head;
   logic [PACKET_WIDTH-1:0] out_head;
   logic                    in_full;
   logic                    in_empty;
   logic                    out_full;
   logic                    out_empty;
   logic [CW-1:0]           in_count;
   logic [CW-1:0]           out_count;
   logic                    in_ovf;
   logic                    out_ovf;
   logic                    cpu_rd;
   logic                    cpu_wr;
   logic                    in_pop;
   logic                    out_push;
   logic                    inject;

   assign cpu_rd   = nicEn && !nicEnWR;
   assign cpu_wr   = nicEn && nicEnWR;
   assign in_pop   = cpu_rd && (addr == ADDR_IN_DATA);
   assign out_push = cpu_wr && (addr == ADDR_OUT_DATA);
   assign inject   = !out_empty && net_ri && (out_head[VC_IDX] == net_polarity);
   assign net_ro   = !in_full;

   sync_fifo #(.WIDTH(PACKET_WIDTH), .DEPTH(DEPTH)) u_in_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (net_si),
      .pop   (in_pop),
      .din   (net_di),
      .head  (in_head),
      .full  (in_full),
      .empty (in_empty),
      .count (in_count)
   );

   sync_fifo #(.WIDTH(PACKET_WIDTH), .DEPTH(DEPTH)) u_out_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (out_push),
      .pop   (inject),
      .din   (d_in),
      .head  (out_head),
      .full  (out_full),
      .empty (out_empty),
      .count (out_count)
   );

   function automatic logic [PACKET_WIDTH-1:0] status_word(input logic b_lsb, input logic b_ovf,
                                                           input logic b_alt, input logic [CW-1:0] cnt);
      logic [PACKET_WIDTH-1:0] s;
      s               = '0;
      s[ST_NE_FULL]   = b_lsb;
      s[ST_OVF]       = b_ovf;
      s[ST_ALT]       = b_alt;
      s[ST_CNT +: CW] = cnt;
      return s;
   endfunction

   // A new overflow on the same edge as a status read keeps the flag set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_ovf  <= 1'b0;
         out_ovf <= 1'b0;
      end else begin
         if (net_si && in_full)                        in_ovf <= 1'b1;
         else if (cpu_rd && (addr == ADDR_IN_STAT))    in_ovf <= 1'b0;
         if (out_push && out_full)                     out_ovf <= 1'b1;
         else if (cpu_rd && (addr == ADDR_OUT_STAT))   out_ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         d_out <= '0;
      end else if (cpu_rd) begin
         case (addr)
            ADDR_IN_DATA:  d_out <= in_empty ? '0 : in_head;
            ADDR_IN_STAT:  d_out <= status_word(!in_empty, in_ovf, in_full, in_count);
            ADDR_OUT_STAT: d_out <= status_word(out_full, out_ovf, out_empty, out_count);
            default:       d_out <= '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         net_so <= 1'b0;
         net_do <= '0;
      end else begin
         net_so <= inject;
         if (inject) net_do <= out_head;
      end
   end

endmodule

// File: tb/tb_nic_fifo.sv
// Directed bench for nic_fifo: injection timing, FIFO fill/drain, overflow flags and reset.
module tb_nic_fifo;

   logic        clk;
   logic        reset;
   logic [1:0]  addr;
   logic [63:0] d_in;
   logic [63:0] d_out;
   logic        nicEn;
   logic        nicEnWR;
   logic        net_si;
   logic        net_ri;
   logic [63:0] net_di;
   logic        net_so;
   logic        net_ro;
   logic [63:0] net_do;
   logic        net_polarity;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic        last_p;
   logic        last_so;
   logic [63:0] last_do;

   localparam logic [63:0] PKT_V0 = 64'h200200000000FA50;
   localparam logic [63:0] PKT_V1 = 64'h8000000000000001;

   nic_fifo #(.PACKET_WIDTH(64), .DEPTH(4), .VC_BIT(0)) dut (
      .clk          (clk),
      .reset        (reset),
      .addr         (addr),
      .d_in         (d_in),
      .d_out        (d_out),
      .nicEn        (nicEn),
      .nicEnWR      (nicEnWR),
      .net_si       (net_si),
      .net_ri       (net_ri),
      .net_di       (net_di),
      .net_so       (net_so),
      .net_ro       (net_ro),
      .net_do       (net_do),
      .net_polarity (net_polarity)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Router polarity flips every cycle, just after the active edge.
   initial begin
      net_polarity = 1'b0;
      forever begin
         @(posedge clk);
         #2 net_polarity = ~net_polarity;
      end
   end

   task automatic cycle(input logic en, input logic wr, input logic [1:0] a, input logic [63:0] d,
                        input logic si, input logic [63:0] di);
      @(negedge clk);
      nicEn = en; nicEnWR = wr; addr = a; d_in = d; net_si = si; net_di = di;
      last_p = net_polarity;
      @(posedge clk);
      #1;
      last_so = net_so;
      last_do = net_do;
      nicEn = 1'b0; net_si = 1'b0;
   endtask

   task automatic cpu_wr(input logic [1:0] a, input logic [63:0] d);
      cycle(1'b1, 1'b1, a, d, 1'b0, 64'h0);
   endtask

   task automatic cpu_rd(input logic [1:0] a);
      cycle(1'b1, 1'b0, a, 64'h0, 1'b0, 64'h0);
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 2'b00, 64'h0, 1'b0, 64'h0);
   endtask

   task automatic net_in(input logic [63:0] di);
      cycle(1'b0, 1'b0, 2'b00, 64'h0, 1'b1, di);
   endtask

   task automatic test_reset();
      reset = 1'b1; addr = 2'b00; d_in = '0; nicEn = 1'b0; nicEnWR = 1'b0;
      net_si = 1'b0; net_ri = 1'b0; net_di = '0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (d_out !== 64'h0) begin n_fail++; $display("FAIL reset_d_out: got %h want 0", d_out); end
      n_checks++; if (net_so !== 1'b0) begin n_fail++; $display("FAIL reset_net_so: got %b want 0", net_so); end
      n_checks++; if (net_do !== 64'h0) begin n_fail++; $display("FAIL reset_net_do: got %h want 0", net_do); end
      n_checks++; if (net_ro !== 1'b1) begin n_fail++; $display("FAIL reset_net_ro: got %b want 1", net_ro); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_single_inject();
      int first_zero, pulse_at, pulses;
      logic [63:0] got;
      net_ri = 1'b1;
      cpu_wr(2'b10, PKT_V0);
      first_zero = -1; pulse_at = -1; pulses = 0; got = '0;
      for (int i = 0; i < 6; i++) begin
         idle();
         if (first_zero < 0 && last_p == 1'b0) first_zero = i;
         if (last_so) begin
            pulses++;
            if (pulse_at < 0) pulse_at = i;
            got = last_do;
         end
      end
      n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL single_pulses: got %0d want 1", pulses); end
      n_checks++; if (pulse_at !== first_zero) begin n_fail++; $display("FAIL single_edge: got %0d want %0d", pulse_at, first_zero); end
      n_checks++; if (got !== PKT_V0) begin n_fail++; $display("FAIL single_net_do: got %h want %h", got, PKT_V0); end
      cpu_rd(2'b11);
      n_checks++; if (d_out !== 64'h4) begin n_fail++; $display("FAIL single_out_stat: got %h want 4", d_out); end
   endtask

   task automatic test_back_to_back();
      logic        pol [8];
      logic [63:0] inj_val [2];
      int          inj_edge [2];
      int          n_inj, e_a, e_b;
      n_inj = 0; e_a = -1; e_b = -1;
      inj_val[0] = '0; inj_val[1] = '0; inj_edge[0] = -1; inj_edge[1] = -1;
      net_ri = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i == 0)      cpu_wr(2'b10, PKT_V1);
         else if (i == 1) cpu_wr(2'b10, PKT_V0);
         else             idle();
         pol[i] = last_p;
         if (last_so) begin
            if (n_inj < 2) begin inj_val[n_inj] = last_do; inj_edge[n_inj] = i; end
            n_inj++;
         end
      end
      for (int i = 1; i < 8; i++) if (e_a < 0 && pol[i] == 1'b1) e_a = i;
      for (int i = 2; i < 8; i++) if (e_b < 0 && i > e_a && pol[i] == 1'b0) e_b = i;
      n_checks++; if (n_inj !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", n_inj); end
      n_checks++; if (inj_val[0] !== PKT_V1) begin n_fail++; $display("FAIL b2b_first_val: got %h want %h", inj_val[0], PKT_V1); end
      n_checks++; if (inj_edge[0] !== e_a) begin n_fail++; $display("FAIL b2b_first_edge: got %0d want %0d", inj_edge[0], e_a); end
      n_checks++; if (inj_val[1] !== PKT_V0) begin n_fail++; $display("FAIL b2b_second_val: got %h want %h", inj_val[1], PKT_V0); end
      n_checks++; if (inj_edge[1] !== e_b) begin n_fail++; $display("FAIL b2b_second_edge: got %0d want %0d", inj_edge[1], e_b); end
   endtask

   task automatic test_out_overflow();
      logic [63:0] seen [4];
      int n_inj;
      net_ri = 1'b0;
      for (int k = 1; k <= 5; k++) cpu_wr(2'b10, 64'h0C00 + 64'(k));
      cpu_rd(2'b11);
      n_checks++; if (d_out !== 64'h23) begin n_fail++; $display("FAIL ovf_out_stat1: got %h want 23", d_out); end
      cpu_rd(2'b11);
      n_checks++; if (d_out !== 64'h21) begin n_fail++; $display("FAIL ovf_out_stat2: got %h want 21", d_out); end
      net_ri = 1'b1;
      n_inj = 0;
      for (int i = 0; i < 12; i++) begin
         idle();
         if (last_so) begin
            if (n_inj < 4) seen[n_inj] = last_do;
            n_inj++;
         end
      end
      n_checks++; if (n_inj !== 4) begin n_fail++; $display("FAIL ovf_drain_count: got %0d want 4", n_inj); end
      for (int k = 0; k < 4 && k < n_inj; k++) begin
         n_checks++;
         if (seen[k] !== 64'h0C01 + 64'(k)) begin
            n_fail++; $display("FAIL ovf_drain_val%0d: got %h want %h", k, seen[k], 64'h0C01 + 64'(k));
         end
      end
   endtask

   task automatic test_in_fill();
      for (int k = 1; k <= 4; k++) begin
         net_in(64'h0A00 + 64'(k));
         n_checks++;
         if (net_ro !== (k < 4)) begin n_fail++; $display("FAIL in_ro_%0d: got %b want %b", k, net_ro, (k < 4)); end
      end
      net_in(64'h0A05);
      cpu_rd(2'b01);
      n_checks++; if (d_out !== 64'h27) begin n_fail++; $display("FAIL in_stat_full: got %h want 27", d_out); end
      for (int k = 1; k <= 4; k++) begin
         cpu_rd(2'b00);
         n_checks++;
         if (d_out !== 64'h0A00 + 64'(k)) begin n_fail++; $display("FAIL in_read_%0d: got %h want %h", k, d_out, 64'h0A00 + 64'(k)); end
      end
      cpu_rd(2'b00);
      n_checks++; if (d_out !== 64'h0) begin n_fail++; $display("FAIL in_read_empty: got %h want 0", d_out); end
      cpu_rd(2'b01);
      n_checks++; if (d_out !== 64'h0) begin n_fail++; $display("FAIL in_stat_empty: got %h want 0", d_out); end
   endtask

   task automatic test_push_pop_same_edge();
      net_in(64'h0B01);
      net_in(64'h0B02);
      cycle(1'b1, 1'b0, 2'b00, 64'h0, 1'b1, 64'h0B03);
      n_checks++; if (d_out !== 64'h0B01) begin n_fail++; $display("FAIL pp_read1: got %h want 0b01", d_out); end
      cpu_rd(2'b01);
      n_checks++; if (d_out !== 64'h11) begin n_fail++; $display("FAIL pp_stat: got %h want 11", d_out); end
      cpu_rd(2'b00);
      n_checks++; if (d_out !== 64'h0B02) begin n_fail++; $display("FAIL pp_read2: got %h want 0b02", d_out); end
      cpu_rd(2'b00);
      n_checks++; if (d_out !== 64'h0B03) begin n_fail++; $display("FAIL pp_read3: got %h want 0b03", d_out); end
   endtask

   task automatic test_reset_mid_op();
      net_ri = 1'b0;
      for (int k = 1; k <= 3; k++) cpu_wr(2'b10, 64'h0D00 + 64'(k));
      for (int k = 1; k <= 3; k++) net_in(64'h0E00 + 64'(k));
      cpu_rd(2'b01);
      n_checks++; if (d_out !== 64'h19) begin n_fail++; $display("FAIL rst_pre_stat: got %h want 19", d_out); end
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_checks++; if (dut.u_in_fifo.count !== 3'd0) begin n_fail++; $display("FAIL rst_in_count: got %0d want 0", dut.u_in_fifo.count); end
      n_checks++; if (dut.u_out_fifo.count !== 3'd0) begin n_fail++; $display("FAIL rst_out_count: got %0d want 0", dut.u_out_fifo.count); end
      n_checks++; if (net_so !== 1'b0) begin n_fail++; $display("FAIL rst_net_so: got %b want 0", net_so); end
      n_checks++; if (d_out !== 64'h0) begin n_fail++; $display("FAIL rst_d_out: got %h want 0", d_out); end
      n_checks++; if (net_ro !== 1'b1) begin n_fail++; $display("FAIL rst_net_ro: got %b want 1", net_ro); end
      n_checks++; if (net_do !== 64'h0) begin n_fail++; $display("FAIL rst_net_do: got %h want 0", net_do); end
      @(negedge clk);
      reset = 1'b0;
      cpu_rd(2'b11);
      n_checks++; if (d_out !== 64'h4) begin n_fail++; $display("FAIL rst_out_stat: got %h want 4", d_out); end
      cpu_rd(2'b01);
      n_checks++; if (d_out !== 64'h0) begin n_fail++; $display("FAIL rst_in_stat: got %h want 0", d_out); end
   endtask

   initial begin
      test_reset();
      test_single_inject();
      test_back_to_back();
      test_out_overflow();
      test_in_fill();
      test_push_pop_same_edge();
      test_reset_mid_op();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
